// File: rtl/or_gate_pkg.sv
// Shared defaults for the registered OR cell used in the match datapath.
package or_gate_pkg;
   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/or_gate.sv
// Registered bitwise OR with a reduction flag, per-bit rise pulses and a
// saturating count of cycles in which any output bit rose.
module or_gate
   import or_gate_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] c,
   output logic             c_any,
   output logic [WIDTH-1:0] c_rise,
   output logic [CNT_W-1:0] rise_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] or_next;
   logic [WIDTH-1:0] rise_next;
   logic             any_rise;
   logic [WIDTH-1:0] c_reg;
   logic [WIDTH-1:0] c_rise_reg;
   logic             c_any_reg;
   logic [CNT_W-1:0] rise_cnt_reg;

   // c_reg doubles as the previous-value register for edge detection.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign or_next[gi]   = a[gi] | b[gi];
      assign rise_next[gi] = or_next[gi] & ~c_reg[gi];
   end

   assign any_rise = |rise_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_reg        <= '0;
         c_any_reg    <= 1'b0;
         c_rise_reg   <= '0;
         rise_cnt_reg <= '0;
      end else begin
         c_reg      <= or_next;
         c_any_reg  <= |or_next;
         c_rise_reg <= rise_next;
         // Clear wins over a coincident rise; the count sticks at all-ones.
         if (cnt_clr) begin
            rise_cnt_reg <= '0;
         end else if (any_rise && (rise_cnt_reg != CNT_MAX)) begin
            rise_cnt_reg <= rise_cnt_reg + 1'b1;
         end
      end
   end

   assign c        = c_reg;
   assign c_any    = c_any_reg;
   assign c_rise   = c_rise_reg;
   assign rise_cnt = rise_cnt_reg;

endmodule

// File: tb/tb_or_gate.sv
// Scoreboard bench for or_gate: a 1-bit/16-bit-counter instance and an
// 8-bit/2-bit-counter instance driven from directed vectors.
module tb_or_gate;

   logic        clk = 1'b0;
   logic        rst;
   logic        n_a, n_b, n_clr;
   logic        n_c, n_any, n_rise;
   logic [15:0] n_cnt;
   logic [7:0]  w_a, w_b, w_c, w_rise;
   logic        w_clr, w_any;
   logic [1:0]  w_cnt;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      bit          wide;
      logic [7:0]  c;
      logic        any;
      logic [7:0]  rise;
      logic [15:0] cnt;
      string       name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   or_gate #(.WIDTH(1), .CNT_W(16)) u_narrow (
      .clk(clk), .rst(rst), .a(n_a), .b(n_b), .cnt_clr(n_clr),
      .c(n_c), .c_any(n_any), .c_rise(n_rise), .rise_cnt(n_cnt)
   );

   or_gate #(.WIDTH(8), .CNT_W(2)) u_wide (
      .clk(clk), .rst(rst), .a(w_a), .b(w_b), .cnt_clr(w_clr),
      .c(w_c), .c_any(w_any), .c_rise(w_rise), .rise_cnt(w_cnt)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every clock the DUTs present a new result; compare against
   // the entry queued when the corresponding inputs were applied.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.wide) begin
            chk({e.name, ".c"},    {8'h0, w_c},     {8'h0, e.c});
            chk({e.name, ".any"},  {15'h0, w_any},  {15'h0, e.any});
            chk({e.name, ".rise"}, {8'h0, w_rise},  {8'h0, e.rise});
            chk({e.name, ".cnt"},  {14'h0, w_cnt},  e.cnt);
         end else begin
            chk({e.name, ".c"},    {15'h0, n_c},    {8'h0, e.c});
            chk({e.name, ".any"},  {15'h0, n_any},  {15'h0, e.any});
            chk({e.name, ".rise"}, {15'h0, n_rise}, {8'h0, e.rise});
            chk({e.name, ".cnt"},  n_cnt,           e.cnt);
         end
         $display("txn %s wide=%0d c=%h rise=%h any=%0d cnt=%0d", e.name, e.wide,
                  e.wide ? w_c : {7'h0, n_c}, e.wide ? w_rise : {7'h0, n_rise},
                  e.wide ? w_any : n_any, e.wide ? {14'h0, w_cnt} : n_cnt);
      end
   end

   task automatic push(input bit wide, input logic [7:0] c, input logic [7:0] rise,
                       input logic [15:0] cnt, input string name);
      exp_t e;
      e.wide = wide; e.c = c; e.any = |c; e.rise = rise; e.cnt = cnt; e.name = name;
      sb.push_back(e);
   endtask

   task automatic drv_n(input logic a, input logic b, input logic clr,
                        input logic c, input logic rise, input int cnt, input string name);
      @(negedge clk);
      n_a = a; n_b = b; n_clr = clr;
      push(1'b0, {7'h0, c}, {7'h0, rise}, cnt[15:0], name);
   endtask

   task automatic drv_w(input logic [7:0] a, input logic [7:0] b, input logic clr,
                        input logic [7:0] c, input logic [7:0] rise, input int cnt,
                        input string name);
      @(negedge clk);
      w_a = a; w_b = b; w_clr = clr;
      push(1'b1, c, rise, cnt[15:0], name);
   endtask

   initial begin
      rst = 1'b1;
      n_a = 1'b1; n_b = 1'b1; n_clr = 1'b0;
      w_a = 8'h0; w_b = 8'h0; w_clr = 1'b0;
      #3;
      chk("rst_c",    {15'h0, n_c},    16'h0);
      chk("rst_any",  {15'h0, n_any},  16'h0);
      chk("rst_rise", {15'h0, n_rise}, 16'h0);
      chk("rst_cnt",  n_cnt,           16'h0);
      $display("txn reset_hold c=%0d any=%0d rise=%0d cnt=%0d", n_c, n_any, n_rise, n_cnt);

      // Release reset with a=b=1 already applied.
      @(negedge clk);
      rst = 1'b0;
      push(1'b0, 8'h1, 8'h1, 16'd1, "rel");

      // Truth table 00,10,11,01.
      drv_n(0, 0, 0, 0, 0, 1, "tt00");
      drv_n(1, 0, 0, 1, 1, 2, "tt10");
      drv_n(1, 1, 0, 1, 0, 2, "tt11");
      drv_n(0, 1, 0, 1, 0, 2, "tt01");

      // Idle low, then overlapping a/b changes keep c high: a single rise.
      for (int i = 0; i < 3; i++) drv_n(0, 0, 0, 0, 0, 2, "idle");
      drv_n(1, 0, 0, 1, 1, 3, "seq_a1");
      drv_n(1, 1, 0, 1, 0, 3, "seq_b1");
      drv_n(0, 1, 0, 1, 0, 3, "seq_a0");
      drv_n(1, 1, 0, 1, 0, 3, "seq_a1b");
      drv_n(1, 1, 0, 1, 0, 3, "seq_hold");
      drv_n(0, 1, 0, 1, 0, 3, "seq_a0b");

      // Fall then re-rise.
      drv_n(1, 1, 0, 1, 0, 3, "fr11");
      drv_n(0, 0, 0, 0, 0, 3, "fr00");
      drv_n(0, 1, 0, 1, 1, 4, "fr01");

      // Clear coincident with a rise.
      drv_n(0, 0, 0, 0, 0, 4, "pre_clr");
      drv_n(1, 0, 1, 1, 1, 0, "clr_rise");
      drv_n(1, 0, 0, 1, 0, 0, "post_clr");

      // Wide instance: full-byte rise from two halves.
      drv_w(8'h0F, 8'hF0, 0, 8'hFF, 8'hFF, 1, "w_full");
      drv_w(8'h0F, 8'hF0, 0, 8'hFF, 8'h00, 1, "w_hold");
      // Toggle bit 0 to drive the 2-bit counter into saturation.
      drv_w(8'h00, 8'h00, 0, 8'h00, 8'h00, 1, "w_t0");
      drv_w(8'h01, 8'h00, 0, 8'h01, 8'h01, 2, "w_t1");
      drv_w(8'h00, 8'h00, 0, 8'h00, 8'h00, 2, "w_t2");
      drv_w(8'h00, 8'h01, 0, 8'h01, 8'h01, 3, "w_t3");
      drv_w(8'h00, 8'h00, 0, 8'h00, 8'h00, 3, "w_t4");
      drv_w(8'h01, 8'h00, 0, 8'h01, 8'h01, 3, "w_sat");
      drv_w(8'h81, 8'h00, 0, 8'h81, 8'h80, 3, "w_part");
      drv_w(8'h81, 8'h02, 1, 8'h83, 8'h02, 0, "w_clr");

      // Asynchronous reset between edges clears everything at once.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_w_c",    {8'h0, w_c},    16'h0);
      chk("arst_w_rise", {8'h0, w_rise}, 16'h0);
      chk("arst_w_any",  {15'h0, w_any}, 16'h0);
      chk("arst_n_c",    {15'h0, n_c},   16'h0);
      chk("arst_n_cnt",  n_cnt,          16'h0);
      $display("txn async_reset w_c=%h n_c=%0d n_cnt=%0d", w_c, n_c, n_cnt);
      @(negedge clk);
      rst = 1'b0;
      n_a = 1'b0; n_b = 1'b0;
      w_a = 8'h83; w_b = 8'h00; w_clr = 1'b0;
      push(1'b1, 8'h83, 8'h83, 16'd1, "w_after_rst");
      drv_w(8'h00, 8'h00, 0, 8'h00, 8'h00, 1, "w_zero");

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
